read_ecall_receiver: RTL and testbench

- Receive side of the Arduino parallel byte link.
- Services the CPU read ecall: accepts `len` bytes strobed in from the external board on an 8-bit bus plus a strobe line.
- Writes each byte, zero-extended, into data memory through the dual-port RAM's second port at `address + offset`.
- Raises `read_ecall_finished` when the transfer completes.
- Sits in the board top level beside the write-ecall transmit path.

---
 rtl/read_ecall_receiver_pkg.sv | 14 +
 rtl/read_ecall_receiver_sync_edge_detect.sv | 38 +++
 rtl/read_ecall_receiver.sv | 172 +++++++++++++++++
 tb/tb_read_ecall_receiver.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/read_ecall_receiver_pkg.sv
// Shared widths, state encoding and defaults for the read-ecall receive path.
package read_ecall_receiver_pkg;

  localparam int BIT_WIDTH              = 64;
  localparam int MEMORY_BITS            = 12;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/read_ecall_receiver_sync_edge_detect.sv
// Synchronises the asynchronous byte bus and strobe through SYNC_STAGES flops
// and emits a single-cycle pulse on each synced strobe rising edge.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       strobe_i,
  output logic [7:0] data_o,
  output logic       edge_o
);

  logic [7:0]             data_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] strobe_q;
  logic                   strobe_prev_q;

  // Data and strobe share the same depth so the byte is stable when the edge fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) data_q[i] <= 8'd0;
      strobe_q      <= '0;
      strobe_prev_q <= 1'b0;
    end else begin
      data_q[0]   <= data_i;
      strobe_q[0] <= strobe_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        data_q[i]   <= data_q[i-1];
        strobe_q[i] <= strobe_q[i-1];
      end
      strobe_prev_q <= strobe_q[SYNC_STAGES-1];
    end
  end

  assign data_o = data_q[SYNC_STAGES-1];
  assign edge_o = strobe_q[SYNC_STAGES-1] & ~strobe_prev_q;

endmodule

// File: rtl/read_ecall_receiver.sv
// Receive side of the parallel byte link: stores len strobed bytes at address+offset.
// Optional idle-strobe timeout enabled with `define READ_ECALL_TIMEOUT_EN.
module read_ecall_receiver
  import read_ecall_receiver_pkg::*;
#(
  parameter int DATA_W         = BIT_WIDTH,
  parameter int ADDR_W         = MEMORY_BITS,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_ecall,
  input  logic [DATA_W-1:0] read_ecall_address,
  input  logic [DATA_W-1:0] read_ecall_len,
  output logic              read_ecall_finished,
  output logic [DATA_W-1:0] read_ecall_count,
  input  logic [7:0]        rx_data,
  input  logic              rx_strobe,
  output logic              rx_ready,
`ifdef READ_ECALL_TIMEOUT_EN
  output logic              rx_timeout,
`endif
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  function automatic logic [DATA_W-1:0] zext_byte(input logic [7:0] b);
    return {{(DATA_W-8){1'b0}}, b};
  endfunction

  logic [7:0] sync_data;
  logic       sync_edge;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .data_i  (rx_data),
    .strobe_i(rx_strobe),
    .data_o  (sync_data),
    .edge_o  (sync_edge)
  );

  state_e            state_q,    state_d;
  logic [ADDR_W-1:0] base_q,     base_d;
  logic [DATA_W-1:0] len_q,      len_d;
  logic [DATA_W-1:0] count_q,    count_d;
  logic              finished_q, finished_d;
  logic              wren_q,     wren_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic [DATA_W-1:0] count_inc;
`ifdef READ_ECALL_TIMEOUT_EN
  logic [DATA_W-1:0] tmo_cnt_q,  tmo_cnt_d;
  logic              timeout_q,  timeout_d;
`endif

  // Upper address bits are beyond the memory and intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^read_ecall_address[DATA_W-1:ADDR_W];

  assign count_inc = count_q + DATA_W'(1);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    count_d    = count_q;
    finished_d = finished_q;
    wren_d     = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef READ_ECALL_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    timeout_d  = timeout_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        finished_d = 1'b1;
        if (read_ecall) begin
          count_d = '0;
          if (read_ecall_len != '0) begin
            base_d     = read_ecall_address[ADDR_W-1:0];
            len_d      = read_ecall_len;
            finished_d = 1'b0;
            state_d    = ST_RECV;
`ifdef READ_ECALL_TIMEOUT_EN
            tmo_cnt_d  = '0;
            timeout_d  = 1'b0;
`endif
          end
        end
      end
      ST_RECV: begin
        if (!read_ecall) begin
          finished_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (sync_edge) begin
          wren_d  = 1'b1;
          addr_d  = base_q + count_q[ADDR_W-1:0];
          wdata_d = zext_byte(sync_data);
          count_d = count_inc;
`ifdef READ_ECALL_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
          if (count_inc == len_q) begin
            finished_d = 1'b1;
            state_d    = ST_DONE;
          end
        end
`ifdef READ_ECALL_TIMEOUT_EN
        else if (tmo_cnt_q >= DATA_W'(TIMEOUT_CYCLES - 1)) begin
          finished_d = 1'b1;
          timeout_d  = 1'b1;
          state_d    = ST_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + DATA_W'(1);
        end
`endif
      end
      ST_DONE: begin
        finished_d = 1'b1;
        if (!read_ecall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      count_q    <= '0;
      finished_q <= 1'b1;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef READ_ECALL_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      count_q    <= count_d;
      finished_q <= finished_d;
      wren_q     <= wren_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
`ifdef READ_ECALL_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign read_ecall_finished = finished_q;
  assign read_ecall_count    = count_q;
  assign rx_ready            = (state_q == ST_RECV);
  assign mem_wren            = wren_q;
  assign mem_addr            = addr_q;
  assign mem_wdata           = wdata_q;
`ifdef READ_ECALL_TIMEOUT_EN
  assign rx_timeout          = timeout_q;
`endif

endmodule

// File: tb/tb_read_ecall_receiver.sv
// Directed bench for read_ecall_receiver; timeout case built with READ_ECALL_TIMEOUT_EN.
module tb_read_ecall_receiver;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              read_ecall = 1'b0;
  logic [DATA_W-1:0] read_ecall_address = '0;
  logic [DATA_W-1:0] read_ecall_len = '0;
  logic              read_ecall_finished;
  logic [DATA_W-1:0] read_ecall_count;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_strobe = 1'b0;
  logic              rx_ready;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
`ifdef READ_ECALL_TIMEOUT_EN
  logic              rx_timeout;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W-1:0] wr_addr [64];
  logic [DATA_W-1:0] wr_data [64];
  int                wr_n = 0;

  read_ecall_receiver #(
    .DATA_W        (DATA_W),
    .ADDR_W        (ADDR_W),
    .SYNC_STAGES   (2),
`ifdef READ_ECALL_TIMEOUT_EN
    .TIMEOUT_CYCLES(50)
`else
    .TIMEOUT_CYCLES(1000000)
`endif
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .read_ecall         (read_ecall),
    .read_ecall_address (read_ecall_address),
    .read_ecall_len     (read_ecall_len),
    .read_ecall_finished(read_ecall_finished),
    .read_ecall_count   (read_ecall_count),
    .rx_data            (rx_data),
    .rx_strobe          (rx_strobe),
    .rx_ready           (rx_ready),
`ifdef READ_ECALL_TIMEOUT_EN
    .rx_timeout         (rx_timeout),
`endif
    .mem_wren           (mem_wren),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wren && wr_n < 64) begin
      wr_addr[wr_n] <= mem_addr;
      wr_data[wr_n] <= mem_wdata;
      wr_n          <= wr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Strobe one byte; the write pulse must appear exactly 3 cycles after the rising strobe.
  task automatic send_byte(input logic [7:0] b, input logic expect_wr, input string tag);
    rx_data   = b;
    rx_strobe = 1'b1;
    step(2);
    check({tag, "_wren_early"}, {63'd0, mem_wren}, 64'd0);
    step(1);
    check({tag, "_wren_lat"}, {63'd0, mem_wren}, {63'd0, expect_wr});
    rx_strobe = 1'b0;
    step(3);
  endtask

  task automatic start(input logic [63:0] addr, input logic [63:0] len);
    read_ecall_address = addr;
    read_ecall_len     = len;
    read_ecall         = 1'b1;
    step(1);
  endtask

  int base_n;

  initial begin
    // Reset state
    step(3);
    rst = 1'b0;
    check("rst_finished", {63'd0, read_ecall_finished}, 64'd1);
    check("rst_ready",    {63'd0, rx_ready}, 64'd0);
    check("rst_wren",     {63'd0, mem_wren}, 64'd0);
    check("rst_addr",     {52'd0, mem_addr}, 64'd0);
    check("rst_wdata",    mem_wdata, 64'd0);
    check("rst_count",    read_ecall_count, 64'd0);
    step(2);

    // Basic transfer
    base_n = wr_n;
    start(64'h100, 64'd4);
    check("basic_fin_low", {63'd0, read_ecall_finished}, 64'd0);
    check("basic_ready",   {63'd0, rx_ready}, 64'd1);
    send_byte(8'h41, 1'b1, "basic0");
    send_byte(8'h42, 1'b1, "basic1");
    send_byte(8'h43, 1'b1, "basic2");
    check("basic_fin_mid", {63'd0, read_ecall_finished}, 64'd0);
    send_byte(8'h0A, 1'b1, "basic3");
    check("basic_nwr",   64'(wr_n - base_n), 64'd4);
    check("basic_a0",    {52'd0, wr_addr[base_n+0]}, 64'h100);
    check("basic_a1",    {52'd0, wr_addr[base_n+1]}, 64'h101);
    check("basic_a2",    {52'd0, wr_addr[base_n+2]}, 64'h102);
    check("basic_a3",    {52'd0, wr_addr[base_n+3]}, 64'h103);
    check("basic_d0",    wr_data[base_n+0], 64'h41);
    check("basic_d1",    wr_data[base_n+1], 64'h42);
    check("basic_d2",    wr_data[base_n+2], 64'h43);
    check("basic_d3",    wr_data[base_n+3], 64'h0A);
    check("basic_fin",   {63'd0, read_ecall_finished}, 64'd1);
    check("basic_count", read_ecall_count, 64'd4);
    check("basic_done_ready", {63'd0, rx_ready}, 64'd0);
    send_byte(8'h55, 1'b0, "done_ign");
    check("done_count", read_ecall_count, 64'd4);
    read_ecall = 1'b0;
    step(2);
    check("idle_count_hold", read_ecall_count, 64'd4);

    // Zero length request
    base_n = wr_n;
    start(64'h300, 64'd0);
    step(2);
    check("zero_fin",   {63'd0, read_ecall_finished}, 64'd1);
    check("zero_ready", {63'd0, rx_ready}, 64'd0);
    check("zero_count", read_ecall_count, 64'd0);
    send_byte(8'h99, 1'b0, "zero_strobe");
    check("zero_nwr", 64'(wr_n - base_n), 64'd0);
    read_ecall = 1'b0;
    step(2);

    // Wrap-around; len input changed mid-transfer must be ignored
    base_n = wr_n;
    start(64'hABCD_0000_0000_0FFE, 64'd3);
    read_ecall_len = 64'd1;
    send_byte(8'h11, 1'b1, "wrap0");
    send_byte(8'h22, 1'b1, "wrap1");
    check("wrap_fin_mid", {63'd0, read_ecall_finished}, 64'd0);
    send_byte(8'h33, 1'b1, "wrap2");
    check("wrap_nwr", 64'(wr_n - base_n), 64'd3);
    check("wrap_a0",  {52'd0, wr_addr[base_n+0]}, 64'hFFE);
    check("wrap_a1",  {52'd0, wr_addr[base_n+1]}, 64'hFFF);
    check("wrap_a2",  {52'd0, wr_addr[base_n+2]}, 64'h000);
    check("wrap_d2",  wr_data[base_n+2], 64'h33);
    check("wrap_count", read_ecall_count, 64'd3);
    read_ecall = 1'b0;
    step(2);

    // Strobes in IDLE, then abort after 2 of 5 bytes
    base_n = wr_n;
    send_byte(8'h77, 1'b0, "idle_strobe");
    check("idle_nwr", 64'(wr_n - base_n), 64'd0);
    start(64'h40, 64'd5);
    send_byte(8'h01, 1'b1, "abort0");
    send_byte(8'h02, 1'b1, "abort1");
    read_ecall = 1'b0;
    step(1);
    check("abort_fin",   {63'd0, read_ecall_finished}, 64'd1);
    check("abort_count", read_ecall_count, 64'd2);
    check("abort_ready", {63'd0, rx_ready}, 64'd0);
    check("abort_nwr",   64'(wr_n - base_n), 64'd2);
    step(2);

    // Reset mid-transfer
    start(64'h200, 64'd3);
    send_byte(8'hC1, 1'b1, "rstmid0");
    rst        = 1'b1;
    read_ecall = 1'b0;
    step(1);
    check("rstmid_fin",   {63'd0, read_ecall_finished}, 64'd1);
    check("rstmid_count", read_ecall_count, 64'd0);
    check("rstmid_ready", {63'd0, rx_ready}, 64'd0);
    rst = 1'b0;
    base_n = wr_n;
    send_byte(8'hC2, 1'b0, "rstmid1");
    check("rstmid_nwr", 64'(wr_n - base_n), 64'd0);
    step(2);

`ifdef READ_ECALL_TIMEOUT_EN
    // Timeout after one byte of three
    start(64'h500, 64'd3);
    check("tmo_clear", {63'd0, rx_timeout}, 64'd0);
    send_byte(8'hEE, 1'b1, "tmo0");
    step(20);
    check("tmo_not_yet", {63'd0, rx_timeout}, 64'd0);
    step(40);
    check("tmo_flag",  {63'd0, rx_timeout}, 64'd1);
    check("tmo_fin",   {63'd0, read_ecall_finished}, 64'd1);
    check("tmo_count", read_ecall_count, 64'd1);
    check("tmo_ready", {63'd0, rx_ready}, 64'd0);
    read_ecall = 1'b0;
    step(2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
